digits_to_number: RTL

Sequential base-to-binary converter: takes a packed vector of NUM_DIGITS digits in radix BASE and produces the binary value by Horner accumulation (acc = acc*BASE + digit), one digit per clock, most-significant digit first. It is the inverse of the binary-to-digits notation converter and uses the same digit packing (digit i at bits [i*BIT_DEPTH +: BIT_DEPTH], digit 0 least significant). It sits between digit-entry logic (buttons, counters, shift registers) and arithmetic consumers that need a plain binary operand.

---
 rtl/digits_to_number.sv | 119 +++++++++++
 1 files changed

// File: rtl/digits_to_number.sv
// digits_to_number: sequential radix-BASE to binary converter.
// Walks the captured digits from most to least significant, one per clock,
// accumulating acc = acc*BASE + digit. The result registers hold their
// value between conversions and change only on completion or reset.
//
// Handshake: start is a level request, not a pulse. Raising it in IDLE
// captures the digits. Holding it high carries the conversion through to
// DONE, and DONE is held for as long as start stays high. Dropping start
// releases DONE, or aborts an unfinished conversion, and the FSM returns
// to IDLE on the next edge.
module digits_to_number #(
  parameter int BIT_DEPTH  = 8,
  parameter int NUM_DIGITS = 3,
  parameter int BASE       = 10
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic [NUM_DIGITS*BIT_DEPTH-1:0] digits,
  output logic [BIT_DEPTH-1:0]            number,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic                            invalid,
  output logic [1:0]                      state_dbg
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Wide enough for (2^BD-1)*BASE + (2^BD-1) without loss.
  localparam int EW    = 2 * BIT_DEPTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]                      state;
  logic [NUM_DIGITS*BIT_DEPTH-1:0] dig_q;
  logic [BIT_DEPTH-1:0]            acc;
  logic [IDX_W-1:0]                idx;
  logic                            ovf_acc;
  logic                            inv_acc;

  logic [BIT_DEPTH-1:0]            cur_digit;
  logic [EW-1:0]                   exact;
  logic                            step_ovf;
  logic                            step_inv;

  // Pick the digit addressed by idx from the captured vector.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) cur_digit = dig_q[i*BIT_DEPTH +: BIT_DEPTH];
    end
  end

  // One Horner step at full precision, plus the sticky flag updates.
  always_comb begin
    exact    = EW'(acc) * EW'(BASE) + EW'(cur_digit);
    step_ovf = ovf_acc || (exact[EW-1:BIT_DEPTH] != '0);
    step_inv = inv_acc || (cur_digit >= BIT_DEPTH'(BASE));
  end

  // Control FSM, accumulator and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      dig_q    <= '0;
      acc      <= '0;
      idx      <= '0;
      ovf_acc  <= 1'b0;
      inv_acc  <= 1'b0;
      number   <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dig_q   <= digits;
            acc     <= '0;
            idx     <= IDX_W'(NUM_DIGITS - 1);
            ovf_acc <= 1'b0;
            inv_acc <= 1'b0;
            state   <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (!start) begin
            // Abort: the previous completed result stays visible.
            state <= S_IDLE;
          end else begin
            acc     <= exact[BIT_DEPTH-1:0];
            ovf_acc <= step_ovf;
            inv_acc <= step_inv;
            idx     <= idx - IDX_W'(1);
            if (idx == '0) begin
              number   <= exact[BIT_DEPTH-1:0];
              overflow <= step_ovf;
              invalid  <= step_inv;
              state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (!start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy      = (state == S_ACCUM);
    done      = (state == S_DONE);
    state_dbg = state;
  end

endmodule
